// File: rtl/sc_reggeneral_arbiter.sv
// sc_reggeneral_arbiter: write arbiter and sequencer for a bank of general-purpose
// load registers. Picks one requester per transaction, drives the shared data bus,
// pulses exactly one active-low load strobe for one cycle, then acknowledges the winner.
// Optional build macro: REGARB_FIXED_PRIORITY_EN selects lowest-index fixed priority
// instead of the default round-robin.
module sc_reggeneral_arbiter #(
    parameter int DATAWIDTH = 4,
    parameter int NUM_REQ   = 4,
    parameter int ADDRWIDTH = 2
) (
    input  logic                           SC_RegARBITER_CLOCK_50,
    input  logic                           SC_RegARBITER_RESET_InLow,
    input  logic [NUM_REQ-1:0]             SC_RegARBITER_req_InBUS,
    input  logic [NUM_REQ*ADDRWIDTH-1:0]   SC_RegARBITER_addr_InBUS,
    input  logic [NUM_REQ*DATAWIDTH-1:0]   SC_RegARBITER_data_InBUS,
    output logic [(1<<ADDRWIDTH)-1:0]      SC_RegARBITER_load_OutLowBUS,
    output logic [DATAWIDTH-1:0]           SC_RegARBITER_data_OutBUS,
    output logic [NUM_REQ-1:0]             SC_RegARBITER_ack_OutBUS,
    output logic                           SC_RegARBITER_busy_Out
);

    localparam int          IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned NR = NUM_REQ;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ACK
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [IW-1:0]          win;
    logic [IW-1:0]          winner_q;
    logic [ADDRWIDTH-1:0]   addr_q;
    logic [DATAWIDTH-1:0]   data_q;

`ifdef REGARB_FIXED_PRIORITY_EN
    // Fixed priority: lowest-index active request wins.
    always_comb begin
        logic found;
        win   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NR; k++) begin
            if (!found && SC_RegARBITER_req_InBUS[k]) begin
                win   = IW'(k);
                found = 1'b1;
            end
        end
    end
`else
    logic [IW-1:0] last_grant;

    // Round-robin pointer: remembers the most recently acknowledged requester.
    always_ff @(posedge SC_RegARBITER_CLOCK_50) begin
        if (!SC_RegARBITER_RESET_InLow)
            last_grant <= IW'(NR - 1);
        else if (state == ACK)
            last_grant <= winner_q;
    end

    // Round-robin search: first active request upward from last_grant+1, wrapping.
    always_comb begin
        logic          found;
        logic [IW-1:0] idx;
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 1; k <= NR; k++) begin
            idx = IW'((32'(last_grant) + k) % NR);
            if (!found && SC_RegARBITER_req_InBUS[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end
`endif

    // State register.
    always_ff @(posedge SC_RegARBITER_CLOCK_50) begin
        if (!SC_RegARBITER_RESET_InLow)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Latch winner index, address and data when a transaction starts.
    always_ff @(posedge SC_RegARBITER_CLOCK_50) begin
        if (!SC_RegARBITER_RESET_InLow) begin
            winner_q <= '0;
            addr_q   <= '0;
            data_q   <= '0;
        end else if (state == IDLE && |SC_RegARBITER_req_InBUS) begin
            winner_q <= win;
            addr_q   <= SC_RegARBITER_addr_InBUS[win*ADDRWIDTH +: ADDRWIDTH];
            data_q   <= SC_RegARBITER_data_InBUS[win*DATAWIDTH +: DATAWIDTH];
        end
    end

    // Next-state logic: IDLE -> LOAD -> ACK -> IDLE, one cycle in each busy state.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (|SC_RegARBITER_req_InBUS) state_next = LOAD;
            LOAD:    state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Moore outputs decoded from registered state and latched transaction fields.
    always_comb begin
        SC_RegARBITER_load_OutLowBUS = '1;
        SC_RegARBITER_ack_OutBUS     = '0;
        SC_RegARBITER_busy_Out       = (state != IDLE);
        SC_RegARBITER_data_OutBUS    = data_q;
        if (state == LOAD)
            SC_RegARBITER_load_OutLowBUS[addr_q] = 1'b0;
        if (state == ACK)
            SC_RegARBITER_ack_OutBUS[winner_q] = 1'b1;
    end

endmodule
